prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, output, 1, meaning fetch request to bus.
REQ-006 The block SHALL have port req_addr, output, 32, meaning word-aligned fetch address.
REQ-007 The block SHALL have port req_ready, input, 1, meaning bus accepts request this cycle.
REQ-008 The block SHALL have port rsp_valid, input, 1, meaning fetch data returned.
REQ-009 The block SHALL have port rsp_data, input, 32, meaning fetched word.
REQ-010 The block SHALL have port instr_valid, output, 1, meaning queue head holds an instruction.
REQ-011 The block SHALL have port instr, output, 32, meaning head instruction (Thumb: zero-extended halfword).
REQ-012 The block SHALL have port instr_pc, output, 32, meaning address of head instruction.
REQ-013 The block SHALL have port instr_ready, input, 1, meaning consumer pops head.
REQ-014 The block SHALL have port flush, input, 1, meaning discard queue and redirect.
REQ-015 The block SHALL have port flush_pc, input, 32, meaning redirect target.
REQ-016 The block SHALL have port flush_thumb, input, 1, meaning mode after redirect (sampled only with flush).
REQ-017 The block SHALL have port level, output, $clog2(DEPTH)+1, meaning current queue occupancy.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DISCARD; at most one request outstanding.
REQ-019 IDLE->REQ when free slots >= 2 (Thumb) or >= 1 (ARM) and no flush; REQ holds req_valid=1, req_addr stable until req_ready.
REQ-020 REQ->WAIT on req_ready; WAIT->IDLE on rsp_valid, pushing data, and fetch_pc advances by 4.
REQ-021 ARM mode: each response SHALL push one entry {rsp_data, fetch_pc}.
REQ-022 Thumb mode: each response SHALL push low half (pc=fetch_pc) then high half (pc=fetch_pc+2); if skip_low set (redirect with bit1=1), only high half is pushed and skip_low clears.
REQ-023 Pushed entries SHALL appear on instr_valid the cycle after rsp_valid (1-cycle latency); no bypass.
REQ-024 Pop SHALL occur when instr_valid && instr_ready; push and pop in the same cycle SHALL both take effect, level adjusted by net count.
REQ-025 Full: no new request issued unless space for a whole response exists; a response SHALL never be dropped for lack of space.
REQ-026 Empty: instr_valid=0, instr and instr_pc hold last value; instr_ready ignored.
REQ-027 Flush SHALL empty queue (level=0, instr_valid=0 next cycle), set fetch_pc={flush_pc[31:2],2'b00}, mode=flush_thumb, skip_low=flush_thumb&flush_pc[1]; ARM ignores flush_pc[1:0].
REQ-028 Flush has priority over same-cycle pop and push; a same-cycle rsp_valid SHALL be discarded.
REQ-029 Flush in WAIT, or in REQ with req_ready=1 same cycle, SHALL go to DISCARD; DISCARD drops next rsp_valid, then IDLE.
REQ-030 Flush in REQ with req_ready=0 SHALL deassert req_valid next cycle and go IDLE (abandoned request never presented as accepted).
REQ-031 Flush in DISCARD SHALL stay DISCARD with updated fetch_pc/mode.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 On reset_n=0 (any time, async): state=IDLE, level=0, pointers=0, req_valid=0, req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, mode=ARM, skip_low=0, fetch_pc=RESET_PC.
REQ-034 An outstanding response arriving after reset release SHALL be ignored (state IDLE does not accept rsp_valid).

Structure
REQ-035 fetch_state_t and prefetch_entry_t {instr, pc} SHALL live in cpu_types_pkg.
REQ-036 Storage SHALL be sub-module prefetch_fifo (DEPTH-parameterised, 1-or-2 push, 1 pop).

Verification
REQ-037 ARM, rsp after 1 cycle, instr_ready=1, RESET_PC=0: instr_pc 0,4,8,... each with rsp_data; first instr_valid 1 cycle after first rsp_valid.
REQ-038 Thumb flush to 0x102, rsp 0xAAAA_BBBB then 0xCCCC_DDDD: instr 0xAAAA pc 0x102, then 0xDDDD pc 0x104, 0xCCCC pc 0x106.
REQ-039 DEPTH=4, instr_ready=0: level reaches 4, req_valid stays 0; one pop -> one new request, level returns to 4.
REQ-040 Flush to 0x200 in WAIT: response for old address dropped; next req_addr=0x200, first instr_pc=0x200.
REQ-041 Flush with simultaneous rsp_valid and pop: level=0 next cycle, no instr_valid until fetch from flush_pc returns.
REQ-042 reset_n pulsed low mid-WAIT: outputs at reset values immediately; late rsp_valid ignored; next req_addr=RESET_PC.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared fetch-path types: prefetch FSM states, queue entry layout, Thumb halfword helper.
package cpu_types_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } prefetch_entry_t;

  // Zero-extended Thumb halfword (hi selects bits [31:16]) tagged with its address.
  function automatic prefetch_entry_t half_entry(input logic [XLEN-1:0] word,
                                                 input logic            hi,
                                                 input logic [XLEN-1:0] pc);
    prefetch_entry_t e;
    e.instr = hi ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
    e.pc    = pc;
    return e;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Instruction queue storage: up to two pushes and one pop per cycle, registered head.
module prefetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [1:0]              push_cnt,
  input  prefetch_entry_t         push_data0,
  input  prefetch_entry_t         push_data1,
  input  logic                    pop,
  output logic                    head_valid,
  output prefetch_entry_t         head,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  prefetch_entry_t mem_q [DEPTH];

  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [LW-1:0]   kept;
  logic            head_valid_q, head_valid_d;
  prefetch_entry_t head_q, head_d;
  logic            pop_en;

  // Next head is the oldest surviving entry, or the first pushed one when the queue drains.
  always_comb begin
    pop_en       = pop & head_valid_q;
    kept         = level_q - LW'(pop_en);
    rd_ptr_d     = rd_ptr_q + AW'(pop_en);
    wr_ptr_d     = wr_ptr_q + AW'(push_cnt);
    level_d      = kept + LW'(push_cnt);
    head_valid_d = (level_d != '0);
    head_d       = head_q;
    if (kept != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push_cnt != 2'd0) begin
      head_d = push_data0;
    end
    if (clear) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      level_d      = '0;
      head_valid_d = 1'b0;
      head_d       = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && push_cnt != 2'd0) begin
      mem_q[wr_ptr_q] <= push_data0;
    end
    if (!clear && push_cnt == 2'd2) begin
      mem_q[wr_ptr_q + AW'(1)] <= push_data1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head       = head_q;
  assign level      = level_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: one outstanding bus fetch at a time, ARM/Thumb unpacking, flush redirect.
module prefetch_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   req_valid,
  output logic [31:0]            req_addr,
  input  logic                   req_ready,
  input  logic                   rsp_valid,
  input  logic [31:0]            rsp_data,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [31:0]            instr_pc,
  input  logic                   instr_ready,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  input  logic                   flush_thumb,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            thumb_q, thumb_d;
  logic            skip_low_q, skip_low_d;
  logic            req_valid_q, req_valid_d;
  logic [31:0]     req_addr_q, req_addr_d;

  logic [1:0]      push_cnt;
  prefetch_entry_t push_data0, push_data1;
  prefetch_entry_t head;
  logic [LW-1:0]   free;
  logic            space_ok;
  logic            unused_flush_bit0;

  // Byte-offset bit 0 has no meaning for word or halfword redirects.
  assign unused_flush_bit0 = flush_pc[0];

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    thumb_d     = thumb_q;
    skip_low_d  = skip_low_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    push_cnt    = 2'd0;
    push_data0  = '0;
    push_data1  = '0;
    // A request is only issued when the whole response is guaranteed to fit.
    free        = LW'(DEPTH) - level;
    space_ok    = thumb_q ? (free >= LW'(2)) : (free >= LW'(1));

    unique case (state_q)
      ST_IDLE: begin
        if (!flush && space_ok) begin
          state_d     = ST_REQ;
          req_valid_d = 1'b1;
          req_addr_d  = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (flush) begin
          state_d     = req_ready ? ST_DISCARD : ST_IDLE;
          req_valid_d = 1'b0;
        end else if (req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        // A response coinciding with flush retires the outstanding fetch, so nothing is left to drop.
        if (flush) begin
          state_d = rsp_valid ? ST_IDLE : ST_DISCARD;
        end else if (rsp_valid) begin
          state_d    = ST_IDLE;
          fetch_pc_d = fetch_pc_q + 32'd4;
          skip_low_d = 1'b0;
          if (!thumb_q) begin
            push_cnt         = 2'd1;
            push_data0.instr = rsp_data;
            push_data0.pc    = fetch_pc_q;
          end else if (skip_low_q) begin
            push_cnt   = 2'd1;
            push_data0 = half_entry(rsp_data, 1'b1, fetch_pc_q + 32'd2);
          end else begin
            push_cnt   = 2'd2;
            push_data0 = half_entry(rsp_data, 1'b0, fetch_pc_q);
            push_data1 = half_entry(rsp_data, 1'b1, fetch_pc_q + 32'd2);
          end
        end
      end
      ST_DISCARD: begin
        if (rsp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      fetch_pc_d = {flush_pc[31:2], 2'b00};
      thumb_d    = flush_thumb;
      skip_low_d = flush_thumb & flush_pc[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      thumb_q     <= 1'b0;
      skip_low_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      thumb_q     <= thumb_d;
      skip_low_q  <= skip_low_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (flush),
    .push_cnt   (push_cnt),
    .push_data0 (push_data0),
    .push_data1 (push_data1),
    .pop        (instr_ready),
    .head_valid (instr_valid),
    .head       (head),
    .level      (level)
  );

  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;
  assign instr     = head.instr;
  assign instr_pc  = head.pc;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: bus responder feeds a scoreboard of expected instructions checked at pop.
module tb_prefetch_queue;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        flush_thumb;
  logic [2:0]  level;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  prefetch_entry_t exp_q[$];

  // Bus responder and reference fetch model.
  logic        pend = 1'b0;
  logic        pend_stale = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int unsigned cnt = 0;
  int unsigned lat = 0;
  int unsigned n_req = 0;
  logic [31:0] m_pc = 32'h0;
  logic        m_thumb = 1'b0;
  logic        m_skip = 1'b0;
  logic [31:0] w;

  prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .flush_thumb (flush_thumb),
    .level       (level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h100) return 32'hAAAA_BBBB;
    if (a == 32'h104) return 32'hCCCC_DDDD;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (rsp_valid) begin
      if (!pend_stale && !flush && reset_n) begin
        w = word_at(m_pc);
        if (!m_thumb) begin
          exp_q.push_back(prefetch_entry_t'{instr: w, pc: m_pc});
        end else begin
          if (!m_skip) exp_q.push_back(prefetch_entry_t'{instr: {16'h0, w[15:0]}, pc: m_pc});
          exp_q.push_back(prefetch_entry_t'{instr: {16'h0, w[31:16]}, pc: m_pc + 32'd2});
        end
        m_pc   = m_pc + 32'd4;
        m_skip = 1'b0;
      end
      pend = 1'b0;
    end
    if (reset_n && req_valid && req_ready) begin
      n_checks++;
      if (req_addr !== m_pc) begin
        n_fail++;
        $display("FAIL req_addr: got %h required %h", req_addr, m_pc);
      end
      pend       = 1'b1;
      pend_stale = flush;
      pend_addr  = req_addr;
      cnt        = lat;
      n_req++;
    end
    if (reset_n && flush) begin
      m_pc    = {flush_pc[31:2], 2'b00};
      m_thumb = flush_thumb;
      m_skip  = flush_thumb & flush_pc[1];
      if (pend) pend_stale = 1'b1;
    end
    #1;
    rsp_valid = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = word_at(pend_addr);
      end else begin
        cnt--;
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks += 6;
    if (req_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_req_valid: got %b required 0", req_valid); end
    if (req_addr !== 32'h0)     begin n_fail++; $display("FAIL rst_req_addr: got %h required 0", req_addr); end
    if (instr_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_instr_valid: got %b required 0", instr_valid); end
    if (instr !== 32'h0)        begin n_fail++; $display("FAIL rst_instr: got %h required 0", instr); end
    if (instr_pc !== 32'h0)     begin n_fail++; $display("FAIL rst_instr_pc: got %h required 0", instr_pc); end
    if (level !== 3'd0)         begin n_fail++; $display("FAIL rst_level: got %0d required 0", level); end
    reset_n = 1'b1;
  endtask

  task automatic test_arm_stream();
    prefetch_entry_t e;
    bit saw_rsp = 0;
    bit lat_done = 0;
    int unsigned pops = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      if (saw_rsp && !lat_done) begin
        lat_done = 1;
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL arm_latency: instr_valid %b required 1", instr_valid); end
      end
      if (rsp_valid && !saw_rsp) begin
        saw_rsp = 1;
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL arm_no_bypass: instr_valid %b required 0", instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        n_checks++;
        pops++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL arm_pop: got %h@%h, nothing expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++; $display("FAIL arm_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
          end
        end
      end
    end
    n_checks++;
    if (pops < 10) begin n_fail++; $display("FAIL arm_pop_count: got %0d required >= 10", pops); end
  endtask

  task automatic test_full();
    prefetch_entry_t e;
    int unsigned rv_cnt = 0;
    int unsigned req_before;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d required 4", level); end
    repeat (8) begin
      @(negedge clk);
      if (req_valid) rv_cnt++;
    end
    n_checks++;
    if (rv_cnt != 0) begin n_fail++; $display("FAIL full_no_req: req_valid seen %0d cycles required 0", rv_cnt); end
    req_before = n_req;
    @(negedge clk);
    instr_ready = 1'b1;
    n_checks++;
    if (!instr_valid) begin
      n_fail++; $display("FAIL full_pop: instr_valid %b required 1", instr_valid);
    end else if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL full_pop: got %h@%h, nothing expected", instr, instr_pc);
    end else begin
      e = exp_q.pop_front();
      if (instr !== e.instr || instr_pc !== e.pc) begin
        n_fail++; $display("FAIL full_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
      end
    end
    @(negedge clk);
    instr_ready = 1'b0;
    n_checks++;
    if (level !== 3'd3) begin n_fail++; $display("FAIL full_after_pop: level %0d required 3", level); end
    repeat (12) @(negedge clk);
    n_checks += 2;
    if (level !== 3'd4) begin n_fail++; $display("FAIL full_refill: level %0d required 4", level); end
    if (n_req - req_before != 1) begin n_fail++; $display("FAIL full_one_req: got %0d requests required 1", n_req - req_before); end
  endtask

  task automatic test_thumb();
    prefetch_entry_t e;
    logic [31:0] ci [3];
    logic [31:0] cp [3];
    int unsigned k = 0;
    ci[0] = 32'h0000_AAAA; cp[0] = 32'h102;
    ci[1] = 32'h0000_DDDD; cp[1] = 32'h104;
    ci[2] = 32'h0000_CCCC; cp[2] = 32'h106;
    @(negedge clk);
    instr_ready = 1'b1;
    flush = 1'b1; flush_pc = 32'h102; flush_thumb = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    n_checks += 2;
    if (level !== 3'd0)       begin n_fail++; $display("FAIL thumb_flush_level: got %0d required 0", level); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL thumb_flush_valid: got %b required 0", instr_valid); end
    for (int c = 0; c < 30; c++) begin
      if (c != 0) @(negedge clk);
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (k < 3 && (instr !== ci[k] || instr_pc !== cp[k])) begin
          n_fail++; $display("FAIL thumb_fixed: got %h@%h required %h@%h", instr, instr_pc, ci[k], cp[k]);
        end
        k++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL thumb_pop: got %h@%h, nothing expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++; $display("FAIL thumb_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
          end
        end
      end
    end
    n_checks++;
    if (k < 3) begin n_fail++; $display("FAIL thumb_pop_count: got %0d required >= 3", k); end
  endtask

  task automatic test_flush_wait();
    prefetch_entry_t e;
    bit found = 0;
    bit addr_seen = 0;
    bit first_seen = 0;
    lat = 3;
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'h40; flush_thumb = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      flush = 1'b0;
      if (req_valid && req_ready) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL fw_setup: no request within 20 cycles"); end
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'h200; flush_thumb = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      flush = 1'b0;
      if (req_valid && !addr_seen) begin
        addr_seen = 1;
        n_checks++;
        if (req_addr !== 32'h200) begin n_fail++; $display("FAIL fw_req_addr: got %h required 00000200", req_addr); end
      end
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (!first_seen) begin
          first_seen = 1;
          if (instr_pc !== 32'h200) begin n_fail++; $display("FAIL fw_first_pc: got %h required 00000200", instr_pc); end
        end
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL fw_pop: got %h@%h, nothing expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++; $display("FAIL fw_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
          end
        end
      end
    end
    n_checks++;
    if (!first_seen) begin n_fail++; $display("FAIL fw_no_output: got 0 pops required >= 1"); end
  endtask

  task automatic test_flush_rsp_pop();
    prefetch_entry_t e;
    bit found = 0;
    bit seen_rsp = 0;
    bit first_seen = 0;
    lat = 0;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (15) @(negedge clk);
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      if (rsp_valid && instr_valid) begin
        found = 1;
        flush = 1'b1; flush_pc = 32'h300; flush_thumb = 1'b0;
        exp_q.delete();
      end else if (instr_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL frp_pre_pop: got %h@%h, nothing expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++; $display("FAIL frp_pre_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
          end
        end
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL frp_setup: no rsp+pop cycle within 30 cycles"); end
    @(negedge clk);
    flush = 1'b0;
    n_checks += 2;
    if (level !== 3'd0)       begin n_fail++; $display("FAIL frp_level: got %0d required 0", level); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL frp_valid: got %b required 0", instr_valid); end
    for (int c = 0; c < 25; c++) begin
      if (c != 0) @(negedge clk);
      n_checks++;
      if (instr_valid && !seen_rsp) begin n_fail++; $display("FAIL frp_early_valid: instr_valid 1 required 0 before new response"); end
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (!first_seen) begin
          first_seen = 1;
          if (instr_pc !== 32'h300) begin n_fail++; $display("FAIL frp_first_pc: got %h required 00000300", instr_pc); end
        end
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL frp_pop: got %h@%h, nothing expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++; $display("FAIL frp_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
          end
        end
      end
      if (rsp_valid) seen_rsp = 1;
    end
    n_checks++;
    if (!first_seen) begin n_fail++; $display("FAIL frp_no_output: got 0 pops required >= 1"); end
  endtask

  task automatic test_reset_mid_wait();
    prefetch_entry_t e;
    bit found = 0;
    bit addr_seen = 0;
    bit first_seen = 0;
    lat = 4;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      if (instr_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rmw_pre_pop: got %h@%h, nothing expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++; $display("FAIL rmw_pre_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
          end
        end
      end
      if (req_valid && req_ready) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rmw_setup: no request within 30 cycles"); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks += 5;
    if (req_valid !== 1'b0)   begin n_fail++; $display("FAIL rmw_req_valid: got %b required 0", req_valid); end
    if (req_addr !== 32'h0)   begin n_fail++; $display("FAIL rmw_req_addr: got %h required 0", req_addr); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_instr_valid: got %b required 0", instr_valid); end
    if (instr !== 32'h0)      begin n_fail++; $display("FAIL rmw_instr: got %h required 0", instr); end
    if (level !== 3'd0)       begin n_fail++; $display("FAIL rmw_level: got %0d required 0", level); end
    exp_q.delete();
    m_pc = 32'h0; m_thumb = 1'b0; m_skip = 1'b0;
    if (pend) pend_stale = 1'b1;
    req_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!pend && !req_ready) req_ready = 1'b1;
      if (req_valid && !addr_seen) begin
        addr_seen = 1;
        n_checks++;
        if (req_addr !== 32'h0) begin n_fail++; $display("FAIL rmw_next_addr: got %h required 0", req_addr); end
      end
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (!first_seen) begin
          first_seen = 1;
          if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rmw_first_pc: got %h required 0", instr_pc); end
        end
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rmw_pop: got %h@%h, nothing expected", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.instr || instr_pc !== e.pc) begin
            n_fail++; $display("FAIL rmw_pop: got %h@%h required %h@%h", instr, instr_pc, e.instr, e.pc);
          end
        end
      end
    end
    n_checks++;
    if (!first_seen) begin n_fail++; $display("FAIL rmw_no_output: got 0 pops required >= 1"); end
  endtask

  initial begin
    reset_n     = 1'b0;
    req_ready   = 1'b1;
    instr_ready = 1'b0;
    flush       = 1'b0;
    flush_pc    = 32'h0;
    flush_thumb = 1'b0;
    test_reset();
    test_arm_stream();
    test_full();
    test_thumb();
    test_flush_wait();
    test_flush_rsp_pop();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
